interrupt_request_register_gen: RTL

- Parametrised, clocked successor to the 8259A interrupt request register stage.
- Captures NUM_IRQ asynchronous request pins through a synchroniser and applies a per-channel edge or level trigger mode.
- Honours freeze (during INTA sequences) and per-bit clear from the in-service logic.
- Presents registered request bits plus a fixed-priority summary to the priority resolver.

---
 rtl/pic_irr_pkg.sv | 22 ++
 rtl/irr_sync_cell.sv | 29 ++
 rtl/interrupt_request_register_gen.sv | 90 +++++++++
 3 files changed

// File: rtl/pic_irr_pkg.sv
// Shared definitions for the interrupt controller request path: trigger-mode
// encodings, default channel count and the fixed-priority index helper.
package pic_irr_pkg;

    localparam logic TRIG_LEVEL = 1'b1;
    localparam logic TRIG_EDGE  = 1'b0;

    localparam int PIC_NUM_IRQ_DEFAULT = 8;

    // Lowest set bit wins; an empty vector reports index 0.
    function automatic logic [4:0] prio_index(input logic [31:0] vector);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (vector[i]) begin
                idx = 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irr_sync_cell.sv
// Single-bit multi-flop synchroniser for one asynchronous request pin.
module irr_sync_cell #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/interrupt_request_register_gen.sv
// 8259A-style interrupt request register with per-channel edge/level trigger,
// freeze and per-bit clear. Define IRR_STICKY_EDGE_EN to hold edge requests until cleared.
module interrupt_request_register_gen
    import pic_irr_pkg::*;
#(
    parameter int NUM_IRQ     = PIC_NUM_IRQ_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] trigger_mode,
    input  logic               freeze,
    input  logic [NUM_IRQ-1:0] clear_interrupt_request,
    input  logic [NUM_IRQ-1:0] interrupt_request_pin,
    output logic [NUM_IRQ-1:0] interrupt_request_register,
    output logic               any_request,
    output logic [ID_W-1:0]    highest_request_id
);

    logic [NUM_IRQ-1:0] pin_s;
    logic [NUM_IRQ-1:0] arm_q;
    logic [NUM_IRQ-1:0] arm_d;
    logic [NUM_IRQ-1:0] irr_q;
    logic [NUM_IRQ-1:0] irr_d;
    logic [31:0]        irr_ext;

    // Synchroniser flops reset high so a pin held high through reset is not an edge.
    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
        irr_sync_cell #(
            .SYNC_STAGES (SYNC_STAGES),
            .RESET_VAL   (1'b1)
        ) u_sync (
            .clock   (clock),
            .reset_n (reset_n),
            .d       (interrupt_request_pin[g]),
            .q       (pin_s[g])
        );
    end

    // Arm tracks "low seen since last clear" and keeps running while frozen.
    always_comb begin
        arm_d = arm_q;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (clear_interrupt_request[i]) begin
                arm_d[i] = 1'b0;
            end else if (!pin_s[i]) begin
                arm_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        irr_d = irr_q;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (clear_interrupt_request[i]) begin
                irr_d[i] = 1'b0;
            end else if (!freeze) begin
                case (trigger_mode[i])
                    TRIG_LEVEL: irr_d[i] = pin_s[i];
`ifdef IRR_STICKY_EDGE_EN
                    TRIG_EDGE:  irr_d[i] = irr_q[i] | (arm_q[i] & pin_s[i]);
`else
                    TRIG_EDGE:  irr_d[i] = arm_q[i] & pin_s[i];
`endif
                    default:    irr_d[i] = irr_q[i];
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            arm_q <= '0;
            irr_q <= '0;
        end else begin
            arm_q <= arm_d;
            irr_q <= irr_d;
        end
    end

    always_comb begin
        irr_ext = 32'(irr_q);
    end

    assign interrupt_request_register = irr_q;
    assign any_request                = |irr_q;
    assign highest_request_id         = ID_W'(prio_index(irr_ext));

endmodule
